// File: rtl/hazard_scoreboard.sv
// Issue-side hazard unit: tracks in-flight long-latency destinations in the integer and FP
// register files and stalls ID on load-use, scoreboard RAW/WAW and multi-cycle-unit-busy hazards.
module hazard_scoreboard #(
    parameter int unsigned WIDTH_SOURCE = 5,
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [WIDTH_SOURCE-1:0] id_rs1,
    input  logic [WIDTH_SOURCE-1:0] id_rs2,
    input  logic                    id_use_rs1,
    input  logic                    id_use_rs2,
    input  logic                    id_rs1_fp,
    input  logic                    id_rs2_fp,
    input  logic [WIDTH_SOURCE-1:0] id_rd,
    input  logic                    id_rd_fp,
    input  logic                    id_reg_wr,
    input  logic                    id_long_op,
    input  logic                    lu_ready,
    input  logic                    ID_EX_Mem_Rd,
    input  logic [WIDTH_SOURCE-1:0] ID_EX_rd,
    input  logic                    ID_EX_rd_fp,
    input  logic                    lu_done,
    input  logic [WIDTH_SOURCE-1:0] lu_done_rd,
    input  logic                    lu_done_fp,
    input  logic                    id_flush,
    input  logic                    cnt_clr,
    output logic                    Stall,
    output logic                    ID_EX_Bubble,
    output logic [2:0]              hz_cause,
    output logic [CNT_WIDTH-1:0]    stall_cycles
);

    logic [NUM_REGS-1:0] int_pend_q, int_pend_d, fp_pend_q, fp_pend_d;
    logic [NUM_REGS-1:0] int_clr, fp_clr, int_set, fp_set, int_live, fp_live;
    logic                rs1_pend, rs2_pend, rd_pend, rs1_lu, rs2_lu, ex_nz;
    logic                haz_lu, haz_sb, haz_st, issue;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Decode the completion into a per-file clear vector.
    always_comb begin
        int_clr = '0;
        fp_clr  = '0;
        if (lu_done) begin
            if (lu_done_fp) fp_clr[lu_done_rd] = 1'b1;
            else            int_clr[lu_done_rd] = 1'b1;
        end
    end

    // Writeback is write-through, so a register completing this cycle no longer blocks.
    assign int_live = int_pend_q & ~int_clr;
    assign fp_live  = fp_pend_q & ~fp_clr;

    // Hazard detection and stall outputs.
    always_comb begin
        rs1_pend = id_use_rs1 & (id_rs1_fp ? fp_live[id_rs1] : int_live[id_rs1]);
        rs2_pend = id_use_rs2 & (id_rs2_fp ? fp_live[id_rs2] : int_live[id_rs2]);
        rd_pend  = id_reg_wr & (id_rd_fp ? fp_live[id_rd] : int_live[id_rd]);
        // Integer x0 is never a real dependency.
        ex_nz    = ID_EX_rd_fp | (ID_EX_rd != '0);
        rs1_lu   = id_use_rs1 & (id_rs1_fp == ID_EX_rd_fp) & (id_rs1 == ID_EX_rd) & ex_nz;
        rs2_lu   = id_use_rs2 & (id_rs2_fp == ID_EX_rd_fp) & (id_rs2 == ID_EX_rd) & ex_nz;
        haz_lu   = id_valid & ID_EX_Mem_Rd & (rs1_lu | rs2_lu);
        haz_sb   = rs1_pend | rs2_pend | rd_pend;
        haz_st   = id_long_op & ~lu_ready;
        Stall        = id_valid & ~id_flush & (haz_lu | haz_sb | haz_st);
        ID_EX_Bubble = Stall;
        hz_cause     = Stall ? {haz_st, haz_sb, haz_lu} : 3'b000;
        issue = id_valid & ~Stall & ~id_flush & id_long_op & id_reg_wr &
                (id_rd_fp | (id_rd != '0));
    end

    // Scoreboard next state: a same-cycle set beats a clear since it marks a new producer.
    always_comb begin
        int_set = '0;
        fp_set  = '0;
        if (issue) begin
            if (id_rd_fp) fp_set[id_rd] = 1'b1;
            else          int_set[id_rd] = 1'b1;
        end
        int_pend_d    = (int_pend_q & ~int_clr) | int_set;
        int_pend_d[0] = 1'b0;
        fp_pend_d     = (fp_pend_q & ~fp_clr) | fp_set;
    end

    // Saturating stall counter; clear wins over increment.
    always_comb begin
        cnt_d = stall_cycles;
        if (cnt_clr)                           cnt_d = '0;
        else if (Stall && stall_cycles != '1)  cnt_d = stall_cycles + 1'b1;
    end

    // State registers.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            int_pend_q   <= '0;
            fp_pend_q    <= '0;
            stall_cycles <= '0;
        end else begin
            int_pend_q   <= int_pend_d;
            fp_pend_q    <= fp_pend_d;
            stall_cycles <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios then random traffic against a set-based model.
module tb_hazard_scoreboard;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       id_valid, id_use_rs1, id_use_rs2, id_rs1_fp, id_rs2_fp;
    logic [4:0] id_rs1, id_rs2, id_rd, ID_EX_rd, lu_done_rd;
    logic       id_rd_fp, id_reg_wr, id_long_op, lu_ready;
    logic       ID_EX_Mem_Rd, ID_EX_rd_fp, lu_done, lu_done_fp, id_flush, cnt_clr;
    logic       Stall, ID_EX_Bubble, Stall_b, ID_EX_Bubble_b;
    logic [2:0] hz_cause, hz_cause_b;
    logic [15:0] stall_cycles;
    logic [3:0]  stall_cycles_b;

    int checks = 0;
    int errors = 0;

    // Model: set of pending registers keyed by file*32+index, plus stall counts.
    bit          pend_m [64];
    int unsigned cnt16_m, cnt4_m;
    bit          exp_stall;
    logic [2:0]  exp_cause;

    always #5 CLK = ~CLK;

    hazard_scoreboard dut (
        .CLK(CLK), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rs1_fp(id_rs1_fp),
        .id_rs2_fp(id_rs2_fp), .id_rd(id_rd), .id_rd_fp(id_rd_fp), .id_reg_wr(id_reg_wr),
        .id_long_op(id_long_op), .lu_ready(lu_ready), .ID_EX_Mem_Rd(ID_EX_Mem_Rd),
        .ID_EX_rd(ID_EX_rd), .ID_EX_rd_fp(ID_EX_rd_fp), .lu_done(lu_done),
        .lu_done_rd(lu_done_rd), .lu_done_fp(lu_done_fp), .id_flush(id_flush),
        .cnt_clr(cnt_clr), .Stall(Stall), .ID_EX_Bubble(ID_EX_Bubble), .hz_cause(hz_cause),
        .stall_cycles(stall_cycles)
    );

    hazard_scoreboard #(.CNT_WIDTH(4)) dut4 (
        .CLK(CLK), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rs1_fp(id_rs1_fp),
        .id_rs2_fp(id_rs2_fp), .id_rd(id_rd), .id_rd_fp(id_rd_fp), .id_reg_wr(id_reg_wr),
        .id_long_op(id_long_op), .lu_ready(lu_ready), .ID_EX_Mem_Rd(ID_EX_Mem_Rd),
        .ID_EX_rd(ID_EX_rd), .ID_EX_rd_fp(ID_EX_rd_fp), .lu_done(lu_done),
        .lu_done_rd(lu_done_rd), .lu_done_fp(lu_done_fp), .id_flush(id_flush),
        .cnt_clr(cnt_clr), .Stall(Stall_b), .ID_EX_Bubble(ID_EX_Bubble_b),
        .hz_cause(hz_cause_b), .stall_cycles(stall_cycles_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int key(input logic [4:0] idx, input logic fp);
        return (fp ? 32 : 0) + int'(idx);
    endfunction

    function automatic bit is_x0(input logic [4:0] idx, input logic fp);
        return !fp && idx == 5'd0;
    endfunction

    function automatic bit pend_now(input int k);
        return pend_m[k] && !(lu_done && k == key(lu_done_rd, lu_done_fp));
    endfunction

    task automatic compute_expect();
        bit lu, sb, st;
        int ek;
        ek = key(ID_EX_rd, ID_EX_rd_fp);
        lu = 1'b0;
        if (id_valid && ID_EX_Mem_Rd && !is_x0(ID_EX_rd, ID_EX_rd_fp)) begin
            if (id_use_rs1 && key(id_rs1, id_rs1_fp) == ek) lu = 1'b1;
            if (id_use_rs2 && key(id_rs2, id_rs2_fp) == ek) lu = 1'b1;
        end
        sb = (id_use_rs1 && pend_now(key(id_rs1, id_rs1_fp))) ||
             (id_use_rs2 && pend_now(key(id_rs2, id_rs2_fp))) ||
             (id_reg_wr && pend_now(key(id_rd, id_rd_fp)));
        st = id_long_op && !lu_ready;
        exp_stall = id_valid && !id_flush && (lu || sb || st);
        exp_cause = exp_stall ? {st, sb, lu} : 3'b000;
    endtask

    task automatic update_model();
        if (lu_done) pend_m[key(lu_done_rd, lu_done_fp)] = 1'b0;
        if (id_valid && !exp_stall && !id_flush && id_long_op && id_reg_wr &&
            !is_x0(id_rd, id_rd_fp))
            pend_m[key(id_rd, id_rd_fp)] = 1'b1;
        if (cnt_clr) begin
            cnt16_m = 0;
            cnt4_m  = 0;
        end else if (exp_stall) begin
            if (cnt16_m < 65535) cnt16_m++;
            if (cnt4_m < 15) cnt4_m++;
        end
    endtask

    task automatic reset_model();
        foreach (pend_m[i]) pend_m[i] = 1'b0;
        cnt16_m = 0;
        cnt4_m  = 0;
    endtask

    // One cycle: settle, compare against the model, clock, advance the model.
    task automatic step(input string tag);
        #1;
        compute_expect();
        chk({tag, ".stall"}, Stall, exp_stall);
        chk({tag, ".bubble"}, ID_EX_Bubble, exp_stall);
        chk({tag, ".cause"}, hz_cause, exp_cause);
        chk({tag, ".cnt"}, stall_cycles, cnt16_m);
        chk({tag, ".cnt4"}, stall_cycles_b, cnt4_m);
        chk({tag, ".stall4"}, Stall_b, exp_stall);
        @(posedge CLK);
        update_model();
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rs1_fp = 0; id_rs2_fp = 0; id_rd = 0; id_rd_fp = 0; id_reg_wr = 0;
        id_long_op = 0; lu_ready = 1; ID_EX_Mem_Rd = 0; ID_EX_rd = 0; ID_EX_rd_fp = 0;
        lu_done = 0; lu_done_rd = 0; lu_done_fp = 0; id_flush = 0; cnt_clr = 0;
    endtask

    task automatic long_op(input logic [4:0] rd, input logic fp);
        idle();
        id_valid = 1; id_long_op = 1; id_reg_wr = 1; id_rd = rd; id_rd_fp = fp;
    endtask

    task automatic read1(input logic [4:0] rs, input logic fp);
        idle();
        id_valid = 1; id_use_rs1 = 1; id_rs1 = rs; id_rs1_fp = fp;
    endtask

    initial begin
        idle();
        reset_model();
        rst_n = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset.cnt", stall_cycles, 16'd0);
        chk("reset.stall", Stall, 1'b0);
        rst_n = 1;

        // Load-use on rs2, one cycle only.
        idle(); id_valid = 1; id_use_rs2 = 1; id_rs2 = 5; ID_EX_Mem_Rd = 1; ID_EX_rd = 5;
        #1; chk("lu.stall", Stall, 1'b1); chk("lu.cause", hz_cause, 3'b001);
        step("lu");
        ID_EX_Mem_Rd = 0; ID_EX_rd = 0;
        #1; chk("lu.next", Stall, 1'b0);
        step("lu_next");
        idle(); id_valid = 1; id_use_rs2 = 1; id_rs2 = 0; ID_EX_Mem_Rd = 1; ID_EX_rd = 0;
        #1; chk("lu.x0", Stall, 1'b0);
        step("lu_x0");

        // File separation.
        idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5; ID_EX_Mem_Rd = 1; ID_EX_rd = 5;
        ID_EX_rd_fp = 1;
        #1; chk("file.int", Stall, 1'b0);
        step("file_int");
        id_rs1_fp = 1;
        #1; chk("file.fp", Stall, 1'b1);
        step("file_fp");

        // Long RAW: fdiv f3, result 6 cycles later.
        long_op(3, 1);
        step("fdiv");
        for (int i = 0; i < 5; i++) begin
            read1(3, 1);
            #1; chk("raw.stall", Stall, 1'b1); chk("raw.cause", hz_cause, 3'b010);
            step("raw");
        end
        read1(3, 1); lu_done = 1; lu_done_rd = 3; lu_done_fp = 1;
        #1; chk("raw.done", Stall, 1'b0);
        step("raw_done");
        read1(3, 1);
        #1; chk("raw.after", Stall, 1'b0);
        step("raw_after");

        // WAW with simultaneous set and clear on x7.
        long_op(7, 0);
        step("mul1");
        long_op(7, 0);
        #1; chk("waw.stall", Stall, 1'b1); chk("waw.cause", hz_cause, 3'b010);
        step("waw");
        long_op(7, 0); lu_done = 1; lu_done_rd = 7;
        #1; chk("waw.issue", Stall, 1'b0);
        step("waw_issue");
        read1(7, 0);
        #1; chk("waw.still_pend", Stall, 1'b1);
        step("waw_pend");
        idle(); lu_done = 1; lu_done_rd = 7;
        step("waw_clr");

        // Structural hazard and flush.
        long_op(9, 0); lu_ready = 0;
        #1; chk("st.stall", Stall, 1'b1); chk("st.cause", hz_cause, 3'b100);
        step("st");
        id_flush = 1;
        #1; chk("st.flush", Stall, 1'b0); chk("st.flush_cause", hz_cause, 3'b000);
        step("st_flush");
        lu_ready = 1;
        step("st_flush_ready");
        read1(9, 0);
        #1; chk("st.no_pend", Stall, 1'b0);
        step("st_nopend");

        // Counter saturation and clear priority.
        idle(); cnt_clr = 1;
        step("cnt_clr0");
        for (int i = 0; i < 20; i++) begin
            long_op(10, 0); lu_ready = 0;
            step("cnt_run");
        end
        idle();
        chk("cnt.sat4", stall_cycles_b, 4'd15);
        chk("cnt.20", stall_cycles, 16'd20);
        long_op(10, 0); lu_ready = 0; cnt_clr = 1;
        step("cnt_clr_stall");
        chk("cnt.clr16", stall_cycles, 16'd0);
        chk("cnt.clr4", stall_cycles_b, 4'd0);

        // Asynchronous reset with three results in flight.
        long_op(1, 0); step("iss_x1");
        long_op(2, 0); step("iss_x2");
        long_op(4, 1); step("iss_f4");
        read1(1, 0);
        #1; chk("rst.pre", Stall, 1'b1);
        rst_n = 0;
        #1;
        reset_model();
        chk("rst.cnt", stall_cycles, 16'd0);
        chk("rst.x1", Stall, 1'b0);
        id_rs1 = 4; id_rs1_fp = 1;
        #1; chk("rst.f4", Stall, 1'b0);
        rst_n = 1;
        idle(); lu_done = 1; lu_done_rd = 2;
        step("late_done");
        read1(2, 0);
        step("rst_x2");

        // Random traffic, small register window to force collisions.
        for (int n = 0; n < 400; n++) begin
            id_valid     = ($urandom_range(0, 9) < 8);
            id_rs1       = 5'($urandom_range(0, 7));
            id_rs2       = 5'($urandom_range(0, 7));
            id_use_rs1   = 1'($urandom);
            id_use_rs2   = 1'($urandom);
            id_rs1_fp    = 1'($urandom);
            id_rs2_fp    = 1'($urandom);
            id_rd        = 5'($urandom_range(0, 7));
            id_rd_fp     = 1'($urandom);
            id_reg_wr    = 1'($urandom);
            id_long_op   = ($urandom_range(0, 9) < 3);
            lu_ready     = ($urandom_range(0, 3) != 0);
            ID_EX_Mem_Rd = ($urandom_range(0, 9) < 3);
            ID_EX_rd     = 5'($urandom_range(0, 7));
            ID_EX_rd_fp  = 1'($urandom);
            lu_done      = ($urandom_range(0, 9) < 3);
            lu_done_rd   = 5'($urandom_range(0, 7));
            lu_done_fp   = 1'($urandom);
            id_flush     = ($urandom_range(0, 9) == 0);
            cnt_clr      = ($urandom_range(0, 31) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
